// File: rtl/song_mem_ctrl.sv
// Song memory sequencer: steps a per-slot sample pointer on each ac97 ready strobe, reading the
// sample RAM in playback and writing it in record. Optional feature macro: LOOP_PLAYBACK_EN.
module song_mem_ctrl #(
  parameter int unsigned ADDR_W      = 19,
  parameter int unsigned SLOT_BITS   = 4,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned RD_LAT      = 2,
  parameter int unsigned SAMPLE_RATE = 48000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ready,
  input  logic [SLOT_BITS-1:0] song_choice,
  input  logic                 record_mode,
  input  logic                 start_song,
  input  logic                 pause_song,
  input  logic [DATA_W-1:0]    sample_in,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_we,
  output logic [DATA_W-1:0]    mem_wdata,
  output logic [DATA_W-1:0]    sample_out,
  output logic                 sample_valid,
  output logic                 song_done,
  output logic [7:0]           running_time
);

  localparam int unsigned OFF_W  = ADDR_W - SLOT_BITS;
  localparam int unsigned LEN_W  = OFF_W + 1;
  localparam int unsigned NSLOTS = 2 ** SLOT_BITS;
  localparam int unsigned TICK_W = (SAMPLE_RATE > 1) ? $clog2(SAMPLE_RATE) : 1;
  localparam logic [LEN_W-1:0]  SLOT_SIZE = LEN_W'(1) << OFF_W;
  localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(SAMPLE_RATE - 1);

  typedef enum logic [1:0] {IDLE, PLAY, REC, DONE} state_t;

  state_t               state_q, state_d;
  logic [SLOT_BITS-1:0] slot_q;
  logic [LEN_W-1:0]     offset_q;
  logic [LEN_W-1:0]     len_q [NSLOTS];
  logic [TICK_W-1:0]    tick_q;
  logic [RD_LAT-1:0]    rd_pipe_q;

  logic [LEN_W-1:0]     limit_c;
  logic                 step_c;
  logic                 access_c;
  logic                 finish_c;
  logic                 wrap_c;
  logic                 rd_c;

  // Next-state and per-cycle strobes; a start pulse always overrides the current activity.
  always_comb begin
    state_d  = state_q;
    access_c = 1'b0;
    finish_c = 1'b0;
    wrap_c   = 1'b0;
    step_c   = ready && !pause_song && (state_q == PLAY || state_q == REC);
    limit_c  = (state_q == REC) ? SLOT_SIZE : len_q[slot_q];
    if (start_song) begin
      if (record_mode && !song_choice[SLOT_BITS-1]) state_d = DONE;
      else if (record_mode)                         state_d = REC;
      else                                          state_d = PLAY;
    end else if (step_c) begin
      if (offset_q == limit_c) begin
`ifdef LOOP_PLAYBACK_EN
        if (state_q == PLAY && limit_c != '0) begin
          wrap_c = 1'b1;
        end else begin
          finish_c = 1'b1;
          state_d  = DONE;
        end
`else
        finish_c = 1'b1;
        state_d  = DONE;
`endif
      end else begin
        access_c = 1'b1;
      end
    end
    rd_c = access_c && (state_q == PLAY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Pointer, length table, RAM interface and read-valid pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q       <= '0;
      offset_q     <= '0;
      tick_q       <= '0;
      rd_pipe_q    <= '0;
      running_time <= '0;
      song_done    <= 1'b0;
      mem_addr     <= '0;
      mem_we       <= 1'b0;
      mem_wdata    <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      for (int unsigned i = 0; i < NSLOTS; i++) begin
        len_q[i] <= (i < NSLOTS / 2) ? SLOT_SIZE : '0;
      end
    end else begin
      mem_we       <= 1'b0;
      sample_valid <= rd_pipe_q[RD_LAT-1];
      if (rd_pipe_q[RD_LAT-1]) sample_out <= mem_rdata;
      rd_pipe_q <= (rd_pipe_q << 1) | RD_LAT'(rd_c);
      if (start_song) begin
        slot_q       <= song_choice;
        offset_q     <= '0;
        tick_q       <= '0;
        running_time <= '0;
        rd_pipe_q    <= '0;
        sample_valid <= 1'b0;
        song_done    <= record_mode && !song_choice[SLOT_BITS-1];
      end else if (finish_c) begin
        song_done <= 1'b1;
      end else if (wrap_c) begin
        offset_q     <= '0;
        tick_q       <= '0;
        running_time <= '0;
      end else if (access_c) begin
        mem_addr <= {slot_q, offset_q[OFF_W-1:0]};
        if (state_q == REC) begin
          mem_we        <= 1'b1;
          mem_wdata     <= sample_in;
          len_q[slot_q] <= offset_q + LEN_W'(1);
        end
        offset_q <= offset_q + LEN_W'(1);
        if (tick_q == TICK_MAX) begin
          tick_q <= '0;
          if (running_time != 8'hFF) running_time <= running_time + 8'd1;
        end else begin
          tick_q <= tick_q + TICK_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_song_mem_ctrl.sv
// Directed bench for song_mem_ctrl with a small sample RAM model (16-sample slots, RD_LAT=2).
module tb_song_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ready = 1'b0;
  logic [3:0]  song_choice = '0;
  logic        record_mode = 1'b0;
  logic        start_song = 1'b0;
  logic        pause_song = 1'b0;
  logic [15:0] sample_in = '0;
  logic [15:0] mem_rdata;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        song_done;
  logic [7:0]  running_time;

  int errors = 0;
  int checks = 0;

  song_mem_ctrl #(
    .ADDR_W(8), .SLOT_BITS(4), .DATA_W(16), .RD_LAT(2), .SAMPLE_RATE(4)
  ) dut (
    .clk(clk), .reset(reset), .ready(ready), .song_choice(song_choice),
    .record_mode(record_mode), .start_song(start_song), .pause_song(pause_song),
    .sample_in(sample_in), .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .sample_out(sample_out), .sample_valid(sample_valid),
    .song_done(song_done), .running_time(running_time)
  );

  always #5 clk = ~clk;

  // Sample RAM: unwritten words read as 0xA000|addr; one register stage on the read path.
  bit   [15:0] wmem   [256];
  bit          wvalid [256];
  logic [15:0] rdq;
  always @(posedge clk) begin
    if (mem_we) begin
      wmem[mem_addr]   <= mem_wdata;
      wvalid[mem_addr] <= 1'b1;
    end
    rdq <= wvalid[mem_addr] ? wmem[mem_addr] : (16'hA000 | 16'(mem_addr));
  end
  assign mem_rdata = rdq;

  typedef struct {
    logic        start;
    logic        mode;
    logic [3:0]  ch;
    logic        rdy;
    logic        pause;
    logic [15:0] sin;
    logic        chk_addr;
    logic [7:0]  addr;
    logic        we;
    logic [15:0] wdata;
    logic        done;
    logic        valid;
    logic [15:0] sout;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic start, input logic mode, input logic [3:0] ch,
                     input logic rdy, input logic pause, input logic [15:0] sin,
                     input logic chk_addr, input logic [7:0] addr, input logic we,
                     input logic [15:0] wdata, input logic done, input logic valid,
                     input logic [15:0] sout);
    vec_t v;
    v.start = start; v.mode = mode; v.ch = ch; v.rdy = rdy; v.pause = pause; v.sin = sin;
    v.chk_addr = chk_addr; v.addr = addr; v.we = we; v.wdata = wdata; v.done = done;
    v.valid = valid; v.sout = sout;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    start_song = 1'b0; ready = 1'b0; pause_song = 1'b0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic start(input logic [3:0] ch, input logic mode, input logic rdy);
    song_choice = ch; record_mode = mode; start_song = 1'b1; ready = rdy;
    step();
    start_song = 1'b0; ready = 1'b0;
  endtask

  initial begin
    // Reset state
    reset_dut();
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_done", 32'(song_done), 32'h0);
    chk("rst_time", 32'(running_time), 32'h0);
    chk("rst_valid", 32'(sample_valid), 32'h0);
    chk("rst_sout", 32'(sample_out), 32'h0);

    // Full playback of preloaded slot 2
    start(4'd2, 1'b0, 1'b0);
    chk("t1_start_done", 32'(song_done), 32'h0);
    for (int j = 0; j < 18; j++) begin
      ready = (j < 17);
      step();
      if (j < 16) chk("t1_addr", 32'(mem_addr), 32'(8'h20 + j));
      else        chk("t1_addr_hold", 32'(mem_addr), 32'h2F);
      chk("t1_we", 32'(mem_we), 32'h0);
      chk("t1_done", 32'(song_done), (j >= 16) ? 32'h1 : 32'h0);
      chk("t1_time", 32'(running_time), (j < 16) ? 32'((j + 1) / 4) : 32'h4);
      chk("t1_valid", 32'(sample_valid), (j >= 2) ? 32'h1 : 32'h0);
      if (j >= 2) chk("t1_sout", 32'(sample_out), 32'(16'hA020 + j - 2));
    end
    ready = 1'b0;

    // Record slot 9 with a pause, then play it back from the table
    add(1, 1, 4'd9, 0, 0, 16'h0, 0, 8'h00, 0, 16'h0, 0, 0, 16'h0);
    for (int i = 1; i <= 5; i++)
      add(0, 0, 4'd0, 1, 0, 16'(16'h1100 + i), 1, 8'(8'h90 + i - 1), 1,
          16'(16'h1100 + i), 0, 0, 16'h0);
    for (int i = 0; i < 3; i++)
      add(0, 0, 4'd0, 1, 1, 16'hDEAD, 1, 8'h94, 0, 16'h0, 0, 0, 16'h0);
    add(0, 0, 4'd0, 0, 0, 16'h0, 1, 8'h94, 0, 16'h0, 0, 0, 16'h0);
    add(1, 0, 4'd9, 0, 0, 16'h0, 1, 8'h94, 0, 16'h0, 0, 0, 16'h0);
    for (int i = 0; i < 5; i++)
      add(0, 0, 4'd0, 1, 0, 16'h0, 1, 8'(8'h90 + i), 0, 16'h0, 0, (i >= 2),
          16'(16'h1101 + i - 2));
    add(0, 0, 4'd0, 1, 0, 16'h0, 1, 8'h94, 0, 16'h0, 1, 1, 16'h1104);
    add(0, 0, 4'd0, 0, 0, 16'h0, 1, 8'h94, 0, 16'h0, 1, 1, 16'h1105);
    add(0, 0, 4'd0, 0, 0, 16'h0, 1, 8'h94, 0, 16'h0, 1, 0, 16'h0);
    foreach (vecs[k]) begin
      start_song = vecs[k].start; record_mode = vecs[k].mode; song_choice = vecs[k].ch;
      ready = vecs[k].rdy; pause_song = vecs[k].pause; sample_in = vecs[k].sin;
      step();
      if (vecs[k].chk_addr) chk("t2_addr", 32'(mem_addr), 32'(vecs[k].addr));
      chk("t2_we", 32'(mem_we), 32'(vecs[k].we));
      if (vecs[k].we) chk("t2_wdata", 32'(mem_wdata), 32'(vecs[k].wdata));
      chk("t2_done", 32'(song_done), 32'(vecs[k].done));
      chk("t2_valid", 32'(sample_valid), 32'(vecs[k].valid));
      if (vecs[k].valid) chk("t2_sout", 32'(sample_out), 32'(vecs[k].sout));
    end
    start_song = 1'b0; ready = 1'b0; pause_song = 1'b0;

    // Record into protected slot 3
    start(4'd3, 1'b1, 1'b0);
    chk("t3_done", 32'(song_done), 32'h1);
    chk("t3_we", 32'(mem_we), 32'h0);
    for (int i = 0; i < 4; i++) begin
      ready = 1'b1; sample_in = 16'h5555;
      step();
      chk("t3_we_run", 32'(mem_we), 32'h0);
      chk("t3_done_run", 32'(song_done), 32'h1);
      chk("t3_addr_hold", 32'(mem_addr), 32'h94);
    end
    ready = 1'b0;

    // Play empty user slot 12 after reset
    reset_dut();
    start(4'd12, 1'b0, 1'b0);
    chk("t4_start_done", 32'(song_done), 32'h0);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("t4_done", 32'(song_done), 32'h1);
    chk("t4_addr", 32'(mem_addr), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_valid", 32'(sample_valid), 32'h0);
    end

    // Async reset in the middle of recording slot 10
    start(4'd10, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      ready = 1'b1; sample_in = 16'(16'h2200 + i);
      step();
    end
    chk("t5_pre_addr", 32'(mem_addr), 32'hA6);
    chk("t5_pre_we", 32'(mem_we), 32'h1);
    chk("t5_pre_time", 32'(running_time), 32'h1);
    reset = 1'b1;
    #1;
    chk("t5_addr", 32'(mem_addr), 32'h0);
    chk("t5_we", 32'(mem_we), 32'h0);
    chk("t5_wdata", 32'(mem_wdata), 32'h0);
    chk("t5_time", 32'(running_time), 32'h0);
    chk("t5_done", 32'(song_done), 32'h0);
    ready = 1'b0;
    step();
    reset = 1'b0;
    step();
    start(4'd10, 1'b0, 1'b0);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("t5_play_done", 32'(song_done), 32'h1);
    chk("t5_play_addr", 32'(mem_addr), 32'h0);

    // Restart with a coincident ready while playing slot 1 at offset 5
    start(4'd1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      ready = 1'b1;
      step();
    end
    chk("t6_pre_addr", 32'(mem_addr), 32'h14);
    start(4'd4, 1'b0, 1'b1);
    chk("t6_start_addr", 32'(mem_addr), 32'h14);
    chk("t6_start_valid", 32'(sample_valid), 32'h0);
    chk("t6_start_done", 32'(song_done), 32'h0);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("t6_addr", 32'(mem_addr), 32'h40);
    chk("t6_flush_valid", 32'(sample_valid), 32'h0);
    step();
    chk("t6_valid_gap", 32'(sample_valid), 32'h0);
    step();
    chk("t6_valid", 32'(sample_valid), 32'h1);
    chk("t6_sout", 32'(sample_out), 32'hA040);
    chk("t6_time", 32'(running_time), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
